// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK/D/T flip-flop channels that can also act as one WIDTH-bit up/down counter.
// Q, CHG and WRAP are all registered. Q_BAR is derived directly from the Q register.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_BAR,
    output logic             CHG,
    output logic             WRAP
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_D     = 2'b01,
        MODE_T     = 2'b10,
        MODE_COUNT = 2'b11
    } mode_t;

    mode_t            mode_sel;
    logic [WIDTH-1:0] q_reg;
    logic             chg_reg;
    logic             wrap_reg;

    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] t_next;
    logic [WIDTH-1:0] count_next;
    logic             count_wrap;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign mode_sel = mode_t'(MODE);

    // Each channel computes its JK, D and T candidates independently.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign jk_next[gi] = (J[gi] & ~q_reg[gi]) | (~K[gi] & q_reg[gi]);
            assign d_next[gi]  = J[gi];
            assign t_next[gi]  = q_reg[gi] ^ J[gi];
        end
    endgenerate

    // J[0] enables counting and K[0] selects down. The wrap condition is taken from Q before the step.
    always_comb begin
        count_next = q_reg;
        count_wrap = 1'b0;
        if (J[0]) begin
            if (K[0]) begin
                count_next = q_reg - WIDTH'(1);
                count_wrap = ~|q_reg;
            end else begin
                count_next = q_reg + WIDTH'(1);
                count_wrap = &q_reg;
            end
        end
    end

    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        case (mode_sel)
            MODE_JK: q_next = jk_next;
            MODE_D:  q_next = d_next;
            MODE_T:  q_next = t_next;
            MODE_COUNT: begin
                q_next    = count_next;
                wrap_next = count_wrap;
            end
            default: q_next = q_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_reg    <= RESET_VAL;
            chg_reg  <= 1'b0;
            wrap_reg <= 1'b0;
        end else if (EN) begin
            q_reg    <= q_next;
            chg_reg  <= (q_next != q_reg);
            wrap_reg <= wrap_next;
        end else begin
            chg_reg  <= 1'b0;
            wrap_reg <= 1'b0;
        end
    end

    assign Q     = q_reg;
    assign Q_BAR = ~q_reg;
    assign CHG   = chg_reg;
    assign WRAP  = wrap_reg;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank with WIDTH=4. Expectations are queued when a step is driven and checked after the edge.
// A second instance with RESET_VAL=1001 receives the same stimulus and is checked where that reset value matters.
module tb_jk_reg_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q_a, q_bar_a, q_b, q_bar_b;
    logic       chg_a, wrap_a, chg_b, wrap_b;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [3:0] q;
        logic       chg;
        logic       wrap;
        bit         check_b;
        logic [3:0] q_b;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .J(j), .K(k),
        .Q(q_a), .Q_BAR(q_bar_a), .CHG(chg_a), .WRAP(wrap_a)
    );

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b1001)) dut_r (
        .CLK(clk), .RST_N(rst_n), .EN(en), .MODE(mode), .J(j), .K(k),
        .Q(q_b), .Q_BAR(q_bar_b), .CHG(chg_b), .WRAP(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs, queue its expectation, then check after the edge on the falling clock.
    task automatic step(input logic rn, input logic e, input logic [1:0] md,
                        input logic [3:0] jj, input logic [3:0] kk,
                        input logic [3:0] eq, input logic ec, input logic ew,
                        input bit cb, input logic [3:0] eqb, input string tag);
        exp_t x;
        rst_n = rn; en = e; mode = md; j = jj; k = kk;
        x.q = eq; x.chg = ec; x.wrap = ew; x.check_b = cb; x.q_b = eqb; x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = exp_q.pop_front();
        n_checks++;
        assert (q_a === x.q) else begin
            n_fails++;
            $error("FAIL %s q: got %b expected %b", x.tag, q_a, x.q);
        end
        n_checks++;
        assert (q_bar_a === ~x.q) else begin
            n_fails++;
            $error("FAIL %s q_bar: got %b expected %b", x.tag, q_bar_a, ~x.q);
        end
        n_checks++;
        assert (chg_a === x.chg) else begin
            n_fails++;
            $error("FAIL %s chg: got %b expected %b", x.tag, chg_a, x.chg);
        end
        n_checks++;
        assert (wrap_a === x.wrap) else begin
            n_fails++;
            $error("FAIL %s wrap: got %b expected %b", x.tag, wrap_a, x.wrap);
        end
        if (x.check_b) begin
            n_checks++;
            assert (q_b === x.q_b) else begin
                n_fails++;
                $error("FAIL %s q_rv: got %b expected %b", x.tag, q_b, x.q_b);
            end
            n_checks++;
            assert (q_bar_b === ~x.q_b) else begin
                n_fails++;
                $error("FAIL %s q_bar_rv: got %b expected %b", x.tag, q_bar_b, ~x.q_b);
            end
            n_checks++;
            assert (chg_b === x.chg && wrap_b === x.wrap) else begin
                n_fails++;
                $error("FAIL %s flags_rv: got chg=%b wrap=%b expected chg=%b wrap=%b",
                       x.tag, chg_b, wrap_b, x.chg, x.wrap);
            end
        end
        $display("step %-10s rst_n=%b en=%b mode=%b j=%b k=%b -> q=%b chg=%b wrap=%b",
                 tag, rn, e, md, jj, kk, q_a, chg_a, wrap_a);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b11; j = 4'b1111; k = 4'b0000;
        @(negedge clk);
        // Reset overrides an active count request.
        step(0, 1, 2'b11, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1, 4'b1001, "reset");

        // JK truth table
        step(1, 1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, "jk_hold");
        step(1, 1, 2'b00, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, "jk_clr");
        step(1, 1, 2'b00, 4'b1111, 4'b0000, 4'b1111, 1, 0, 0, 4'b0000, "jk_set");
        step(1, 1, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000, "jk_tog1");
        step(1, 1, 2'b00, 4'b1111, 4'b1111, 4'b1111, 1, 0, 0, 4'b0000, "jk_tog2");

        // Per-bit independence
        step(1, 1, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000, "jk_clr2");
        step(1, 1, 2'b00, 4'b1010, 4'b0101, 4'b1010, 1, 0, 0, 4'b0000, "jk_mix1");
        step(1, 1, 2'b00, 4'b0011, 4'b0011, 4'b1001, 1, 0, 0, 4'b0000, "jk_mix2");

        // Count wrap up and down. Only J[0]/K[0] matter.
        step(1, 1, 2'b01, 4'b1110, 4'b0000, 4'b1110, 1, 0, 0, 4'b0000, "d_load");
        step(1, 1, 2'b11, 4'b0001, 4'b1110, 4'b1111, 1, 0, 0, 4'b0000, "cnt_up1");
        step(1, 1, 2'b11, 4'b1011, 4'b0000, 4'b0000, 1, 1, 0, 4'b0000, "cnt_wrapu");
        step(1, 1, 2'b11, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 4'b0000, "cnt_up2");
        step(1, 1, 2'b11, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 4'b0000, "cnt_dn1");
        step(1, 1, 2'b11, 4'b0001, 4'b1111, 4'b1111, 1, 1, 0, 4'b0000, "cnt_wrapd");
        step(1, 1, 2'b11, 4'b1110, 4'b0001, 4'b1111, 0, 0, 0, 4'b0000, "cnt_hold");

        // EN low holds Q, even with a pending wrap.
        step(1, 0, 2'b10, 4'b1111, 4'b0000, 4'b1111, 0, 0, 0, 4'b0000, "en_off1");
        step(1, 0, 2'b11, 4'b0001, 4'b0000, 4'b1111, 0, 0, 0, 4'b0000, "en_off2");
        step(1, 0, 2'b10, 4'b1111, 4'b0000, 4'b1111, 0, 0, 0, 4'b0000, "en_off3");
        // T mode 1111 -> 0000 does not raise WRAP.
        step(1, 1, 2'b10, 4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, "en_on_t");

        // Mode switches: Q carries over between modes.
        step(1, 1, 2'b01, 4'b0110, 4'b1001, 4'b0110, 1, 0, 0, 4'b0000, "d_0110");
        step(1, 1, 2'b10, 4'b0011, 4'b1111, 4'b0101, 1, 0, 0, 4'b0000, "t_0011");
        step(1, 1, 2'b11, 4'b0001, 4'b0000, 4'b0110, 1, 0, 0, 4'b0000, "cnt_0110");

        // Reset during counting
        step(1, 1, 2'b01, 4'b0101, 4'b0000, 4'b0101, 1, 0, 1, 4'b0101, "d_0101");
        step(0, 1, 2'b11, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1, 4'b1001, "rst_mid");
        step(1, 1, 2'b11, 4'b0001, 4'b0000, 4'b0001, 1, 0, 1, 4'b1010, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop channels (WIDTH >= 2).
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits), state loaded into Q by reset.
REQ-003 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port RST_N  input  1  reset, synchronous, active-low.
REQ-005 Port EN  input  1  update enable; low = hold.
REQ-006 Port MODE  input  2  per-bank mode: 00 JK, 01 D, 10 T, 11 COUNT.
REQ-007 Port J  input  WIDTH  per-channel J / D / T input; J[0] = count enable in COUNT.
REQ-008 Port K  input  WIDTH  per-channel K input; K[0] = direction in COUNT (0 up, 1 down).
REQ-009 Port Q  output  WIDTH  registered state.
REQ-010 Port Q_BAR  output  WIDTH  bitwise complement of Q, always.
REQ-011 Port CHG  output  1  registered flag: Q changed on the last edge.
REQ-012 Port WRAP  output  1  registered flag: COUNT wrapped on the last edge.

Function
REQ-013 The block SHALL sample all inputs on the CLK rising edge; Q, CHG and WRAP are visible one cycle after the sampling edge; no combinational path from inputs to outputs.
REQ-014 Q_BAR SHALL equal ~Q in every cycle, including during and after reset; never both 1 on any bit.
REQ-015 MODE 00 (JK), per bit i: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
REQ-016 MODE 01 (D), per bit i: Q[i] <= J[i]; K ignored.
REQ-017 MODE 10 (T), per bit i: Q[i] <= Q[i] ^ J[i]; K ignored.
REQ-018 MODE 11 (COUNT): J[0]=1,K[0]=0 -> Q <= Q+1 mod 2^WIDTH; J[0]=1,K[0]=1 -> Q <= Q-1 mod 2^WIDTH; J[0]=0 -> hold; J[WIDTH-1:1], K[WIDTH-1:1] ignored.
REQ-019 WRAP SHALL be 1 for exactly one cycle after an edge where COUNT moved all-ones -> 0 (up) or 0 -> all-ones (down); 0 otherwise, and 0 in all other modes.
REQ-020 CHG SHALL be 1 for the cycle after any edge where the next Q differs from the current Q in at least one bit; 0 when Q is unchanged.
REQ-021 EN=0 SHALL hold Q regardless of MODE/J/K and drive CHG=0, WRAP=0 on that edge.
REQ-022 A MODE change SHALL take effect on the same edge at which the new MODE is sampled; Q carries over unchanged into the new mode (no implicit clear).
REQ-023 Width rule: all COUNT arithmetic is WIDTH bits, modulo 2^WIDTH; the carry/borrow feeds WRAP only.

Reset
REQ-024 RST_N=0 sampled on a rising edge SHALL set Q=RESET_VAL, Q_BAR=~RESET_VAL, CHG=0, WRAP=0, overriding EN, MODE, J, K.
REQ-025 Reset asserted mid-count or mid-toggle SHALL abandon the operation; the first edge with RST_N=1 operates from RESET_VAL.
REQ-026 Before the first reset edge, outputs are undefined; the bench SHALL not check them.

Verification (WIDTH=4, RESET_VAL=0 unless stated)
REQ-027 JK truth table: MODE=00, EN=1, after reset drive J/K = 0000/0000, 0000/1111, 1111/0000, 1111/1111, 1111/1111 on successive edges -> Q = 0000, 0000, 1111, 0000, 1111; CHG = 0,0,1,1,1; Q_BAR = ~Q throughout.
REQ-028 Per-bit independence: MODE=00, Q=0000, J=1010, K=0101 -> Q=1010; then J=0011, K=0011 -> Q=1001.
REQ-029 Count wrap: MODE=11, J[0]=1, K[0]=0 from Q=1110 -> 1111 (WRAP=0) -> 0000 (WRAP=1 one cycle) -> 0001 (WRAP=0); then K[0]=1 -> 0000 -> 1111 with WRAP=1.
REQ-030 Hold: EN=0 with MODE=10, J=1111 for 3 edges -> Q unchanged, CHG=0, WRAP=0; EN=1 next edge -> Q inverted, CHG=1.
REQ-031 Mode switch and D/T: MODE=01, J=0110 -> Q=0110; MODE=10, J=0011 -> Q=0101; MODE=11, J[0]=1, K[0]=0 -> Q=0110.
REQ-032 Reset mid-operation: counting up at Q=0101, RST_N=0 for one edge with RESET_VAL=1001 -> Q=1001, CHG=0, WRAP=0; RST_N=1 next edge -> Q=1010.
